// File: rtl/rv2t_csr_pkg.sv
// Shared constants for the RV2T machine-mode CSR block: CSR addresses,
// access encodings, interrupt cause codes, status/pending bit positions
// and the read-only identification values.
package rv2t_csr_pkg;

   // CSR addresses
   localparam logic [11:0] CSR_MSTATUS       = 12'h300;
   localparam logic [11:0] CSR_MISA          = 12'h301;
   localparam logic [11:0] CSR_MIE           = 12'h304;
   localparam logic [11:0] CSR_MTVEC         = 12'h305;
   localparam logic [11:0] CSR_MCOUNTINHIBIT = 12'h320;
   localparam logic [11:0] CSR_MSCRATCH      = 12'h340;
   localparam logic [11:0] CSR_MEPC          = 12'h341;
   localparam logic [11:0] CSR_MCAUSE        = 12'h342;
   localparam logic [11:0] CSR_MTVAL         = 12'h343;
   localparam logic [11:0] CSR_MIP           = 12'h344;
   localparam logic [11:0] CSR_MCYCLE        = 12'hB00;
   localparam logic [11:0] CSR_MINSTRET      = 12'hB02;
   localparam logic [11:0] CSR_MHPMCOUNTER3  = 12'hB03;
   localparam logic [11:0] CSR_MCYCLEH       = 12'hB80;
   localparam logic [11:0] CSR_MINSTRETH     = 12'hB82;
   localparam logic [11:0] CSR_MHPMCOUNTER3H = 12'hB83;
   localparam logic [11:0] CSR_MVENDORID     = 12'hF11;
   localparam logic [11:0] CSR_MARCHID       = 12'hF12;
   localparam logic [11:0] CSR_MIMPID        = 12'hF13;
   localparam logic [11:0] CSR_MHARTID       = 12'hF14;

   // Offset from a counter's low-half address to its high half
   localparam logic [11:0] CSR_HALF_HI = 12'h080;

   // csr_op encodings
   typedef enum logic [1:0] {
      OP_NONE = 2'b00,
      OP_RW   = 2'b01,
      OP_RS   = 2'b10,
      OP_RC   = 2'b11
   } csr_op_e;

   // Interrupt cause codes
   localparam logic [3:0] IRQ_MSI = 4'd3;
   localparam logic [3:0] IRQ_MTI = 4'd7;
   localparam logic [3:0] IRQ_MEI = 4'd11;

   // mstatus bit positions
   localparam int MSTATUS_MIE    = 3;
   localparam int MSTATUS_MPIE   = 7;
   localparam int MSTATUS_MPP_LO = 11;

   // mip / mie bit positions
   localparam int BIT_MSI = 3;
   localparam int BIT_MTI = 7;
   localparam int BIT_MEI = 11;

   // Identification values
   localparam logic [31:0] MVENDORID_VAL = 32'h0000_0A5B;
   localparam logic [31:0] MARCHID_VAL   = 32'h0000_0025;
   localparam logic [31:0] MIMPID_VAL    = 32'h0001_0000;
   localparam logic [31:0] MHARTID_VAL   = 32'h0000_0000;
   localparam logic [31:0] MISA_VAL      = 32'h4000_1100;   // RV32 I+M

   // Counter index -> offset from mcycle; equals its mcountinhibit bit.
   // 0 = mcycle, 1 = minstret (0xB02), 2+n = mhpmcounter(3+n).
   function automatic int cnt_offset(input int idx);
      return (idx == 0) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/rv2t_csr_counter.sv
// CNT_WIDTH event counter with inhibit, per-32-bit-half load and a shadow
// of the high half captured whenever the low half is read.
module rv2t_csr_counter #(
   parameter int CNT_WIDTH = 64
) (
   input  logic        clk,
   input  logic        sync_reset,
   input  logic        inhibit,
   input  logic        inc,
   input  logic        wr_lo,
   input  logic        wr_hi,
   input  logic        latch_hi,
   input  logic [31:0] wdata,
   output logic [31:0] lo,
   output logic [31:0] hi_shadow
);

   logic [CNT_WIDTH-1:0] cnt_reg;
   logic [31:0]          shadow_reg;
   logic [31:0]          hi_val;

   // High half zero-extended: bits at or above CNT_WIDTH read as zero
   always_comb begin
      hi_val = '0;
      hi_val[CNT_WIDTH-33:0] = cnt_reg[CNT_WIDTH-1:32];
   end

   // Count, with a CSR load taking precedence over this cycle's increment
   always_ff @(posedge clk) begin
      if (sync_reset) begin
         cnt_reg <= '0;
      end else if (wr_lo || wr_hi) begin
         if (wr_lo) cnt_reg[31:0] <= wdata;
         if (wr_hi) cnt_reg[CNT_WIDTH-1:32] <= wdata[CNT_WIDTH-33:0];
      end else if (inc && !inhibit) begin
         cnt_reg <= cnt_reg + CNT_WIDTH'(1);
      end
   end

   // Snapshot the high half so a lo-then-hi read pair is coherent
   always_ff @(posedge clk) begin
      if (sync_reset)    shadow_reg <= '0;
      else if (latch_hi) shadow_reg <= hi_val;
   end

   assign lo        = cnt_reg[31:0];
   assign hi_shadow = shadow_reg;

endmodule

// File: rtl/rv2t_csr_mx.sv
// RV2T machine-mode CSR file: trap entry/return, interrupt pending/enable,
// mtvec-based trap vectoring, cycle/instret counters and optional
// hardware performance counters (compiled in with RV2T_CSR_HPM_EN).
module rv2t_csr_mx
   import rv2t_csr_pkg::*;
#(
   parameter int CNT_WIDTH = 64,
   parameter int NUM_HPM   = 4
) (
   input  logic               clk,
   input  logic               sync_reset,
   input  logic               exe_enable,
   input  logic               csr_req,
   input  logic [1:0]         csr_op,
   input  logic [11:0]        csr_addr,
   input  logic [31:0]        csr_wdata,
   output logic               csr_rvalid,
   output logic [31:0]        csr_rdata,
   output logic               csr_illegal,
   input  logic               irq_sw,
   input  logic               irq_timer,
   input  logic               irq_ext,
   input  logic [NUM_HPM-1:0] hpm_event,
   input  logic               exc_valid,
   input  logic               exc_is_irq,
   input  logic [3:0]         exc_code,
   input  logic [31:0]        exc_pc,
   input  logic [31:0]        exc_tval,
   input  logic               mret,
   output logic [31:0]        trap_vector,
   output logic [31:0]        mepc_out,
   output logic               irq_take,
   output logic [3:0]         irq_code
);

`ifdef RV2T_CSR_HPM_EN
   localparam int          NUM_CNT  = 2 + NUM_HPM;
   localparam logic [31:0] INH_MASK = 32'h5 | (((32'd1 << NUM_HPM) - 32'd1) << 3);
`else
   localparam int          NUM_CNT  = 2;
   localparam logic [31:0] INH_MASK = 32'h5;
   logic unused_hpm;
   assign unused_hpm = ^hpm_event;
`endif

   logic        mstatus_mie_reg, mstatus_mpie_reg;
   logic        msie_reg, mtie_reg, meie_reg;
   logic        msip_reg, mtip_reg, meip_reg, irq_sw_q_reg;
   logic [29:0] mtvec_base_reg;
   logic        mtvec_mode_reg;
   logic [31:0] mscratch_reg, mepc_reg, mcause_reg, mtval_reg, minhibit_reg;
   logic        rvalid_reg, illegal_reg;
   logic [31:0] rdata_reg;

   logic        csr_acc, known, op_writes, illegal, wr_en, sw_rise;
   logic [31:0] old_val, new_val;
   logic [31:0] mstatus_word, mie_word, mip_word;
   logic [31:0] cnt_lo [NUM_CNT];
   logic [31:0] cnt_sh [NUM_CNT];

   // A CSR access only proceeds when no trap entry or return claims the cycle
   assign csr_acc   = csr_req && !exc_valid && !mret;
   assign sw_rise   = irq_sw && !irq_sw_q_reg;
   assign op_writes = (csr_op == OP_RW) || (csr_wdata != 32'd0);
   assign illegal   = !known || (csr_op == OP_NONE) ||
                      ((csr_addr[11:10] == 2'b11) && op_writes);
   assign wr_en     = csr_acc && !illegal && op_writes;

   // Assemble the architectural views of the packed status registers
   always_comb begin
      mstatus_word = '0;
      mstatus_word[MSTATUS_MPP_LO+1:MSTATUS_MPP_LO] = 2'b11;
      mstatus_word[MSTATUS_MPIE] = mstatus_mpie_reg;
      mstatus_word[MSTATUS_MIE]  = mstatus_mie_reg;
      mie_word = '0;
      mie_word[BIT_MSI] = msie_reg;
      mie_word[BIT_MTI] = mtie_reg;
      mie_word[BIT_MEI] = meie_reg;
      mip_word = '0;
      mip_word[BIT_MSI] = msip_reg;
      mip_word[BIT_MTI] = mtip_reg;
      mip_word[BIT_MEI] = meip_reg;
   end

   // Address decode and pre-access read value
   always_comb begin
      old_val = '0;
      known   = 1'b1;
      case (csr_addr)
         CSR_MSTATUS:       old_val = mstatus_word;
         CSR_MISA:          old_val = MISA_VAL;
         CSR_MIE:           old_val = mie_word;
         CSR_MTVEC:         old_val = {mtvec_base_reg, 1'b0, mtvec_mode_reg};
         CSR_MCOUNTINHIBIT: old_val = minhibit_reg;
         CSR_MSCRATCH:      old_val = mscratch_reg;
         CSR_MEPC:          old_val = mepc_reg;
         CSR_MCAUSE:        old_val = mcause_reg;
         CSR_MTVAL:         old_val = mtval_reg;
         CSR_MIP:           old_val = mip_word;
         CSR_MVENDORID:     old_val = MVENDORID_VAL;
         CSR_MARCHID:       old_val = MARCHID_VAL;
         CSR_MIMPID:        old_val = MIMPID_VAL;
         CSR_MHARTID:       old_val = MHARTID_VAL;
         // The whole counter window is legal; unbuilt counters read zero
         default:           known = (csr_addr[11:5] == 7'h58) || (csr_addr[11:5] == 7'h5C);
      endcase
      for (int i = 0; i < NUM_CNT; i++) begin
         if (csr_addr == CSR_MCYCLE + 12'(cnt_offset(i)))
            old_val = cnt_lo[i];
         if (csr_addr == (CSR_MCYCLE + 12'(cnt_offset(i))) + CSR_HALF_HI)
            old_val = cnt_sh[i];
      end
   end

   // Read-modify-write result
   always_comb begin
      case (csr_op)
         OP_RS:   new_val = old_val | csr_wdata;
         OP_RC:   new_val = old_val & ~csr_wdata;
         default: new_val = csr_wdata;
      endcase
   end

   // Trap state, interrupt sampling and CSR writes (trap > mret > CSR)
   always_ff @(posedge clk) begin
      if (sync_reset) begin
         mstatus_mie_reg  <= 1'b0;
         mstatus_mpie_reg <= 1'b0;
         msie_reg         <= 1'b0;
         mtie_reg         <= 1'b0;
         meie_reg         <= 1'b0;
         msip_reg         <= 1'b0;
         mtip_reg         <= 1'b0;
         meip_reg         <= 1'b0;
         irq_sw_q_reg     <= 1'b0;
         mtvec_base_reg   <= '0;
         mtvec_mode_reg   <= 1'b0;
         mscratch_reg     <= '0;
         mepc_reg         <= '0;
         mcause_reg       <= '0;
         mtval_reg        <= '0;
         minhibit_reg     <= '0;
      end else begin
         irq_sw_q_reg <= irq_sw;
         mtip_reg     <= irq_timer;
         meip_reg     <= irq_ext;
         // A software-interrupt edge beats a same-cycle clearing write
         if (wr_en && csr_addr == CSR_MIP) msip_reg <= new_val[BIT_MSI] | sw_rise;
         else if (sw_rise)                 msip_reg <= 1'b1;
         if (exc_valid) begin
            mepc_reg         <= {exc_pc[31:1], 1'b0};
            mcause_reg       <= {exc_is_irq, 27'd0, exc_code};
            mtval_reg        <= exc_tval;
            mstatus_mpie_reg <= mstatus_mie_reg;
            mstatus_mie_reg  <= 1'b0;
         end else if (mret) begin
            mstatus_mie_reg  <= mstatus_mpie_reg;
            mstatus_mpie_reg <= 1'b1;
         end else if (wr_en) begin
            case (csr_addr)
               CSR_MSTATUS: begin
                  mstatus_mie_reg  <= new_val[MSTATUS_MIE];
                  mstatus_mpie_reg <= new_val[MSTATUS_MPIE];
               end
               CSR_MIE: begin
                  msie_reg <= new_val[BIT_MSI];
                  mtie_reg <= new_val[BIT_MTI];
                  meie_reg <= new_val[BIT_MEI];
               end
               CSR_MTVEC: begin
                  mtvec_base_reg <= new_val[31:2];
                  mtvec_mode_reg <= new_val[1] ? 1'b0 : new_val[0];
               end
               CSR_MCOUNTINHIBIT: minhibit_reg <= new_val & INH_MASK;
               CSR_MSCRATCH:      mscratch_reg <= new_val;
               CSR_MEPC:          mepc_reg     <= {new_val[31:1], 1'b0};
               CSR_MCAUSE:        mcause_reg   <= new_val;
               CSR_MTVAL:         mtval_reg    <= new_val;
               default: ;
            endcase
         end
      end
   end

   // Registered access response, one cycle after an accepted request
   always_ff @(posedge clk) begin
      if (sync_reset) begin
         rvalid_reg  <= 1'b0;
         illegal_reg <= 1'b0;
         rdata_reg   <= '0;
      end else begin
         rvalid_reg  <= csr_acc;
         illegal_reg <= csr_acc && illegal;
         rdata_reg   <= (csr_acc && !illegal) ? old_val : 32'd0;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < NUM_CNT; gi++) begin : g_cnt
         localparam logic [11:0] LO_ADDR = CSR_MCYCLE + 12'(cnt_offset(gi));
         logic inc_evt;
         if (gi == 0) begin : g_cy
            assign inc_evt = 1'b1;
         end else if (gi == 1) begin : g_ir
            assign inc_evt = exe_enable;
         end else begin : g_hpm
            assign inc_evt = hpm_event[gi-2];
         end
         rv2t_csr_counter #(.CNT_WIDTH(CNT_WIDTH)) u_cnt (
            .clk       (clk),
            .sync_reset(sync_reset),
            .inhibit   (minhibit_reg[cnt_offset(gi)]),
            .inc       (inc_evt),
            .wr_lo     (wr_en && csr_addr == LO_ADDR),
            .wr_hi     (wr_en && csr_addr == LO_ADDR + CSR_HALF_HI),
            .latch_hi  (csr_acc && !illegal && csr_addr == LO_ADDR),
            .wdata     (new_val),
            .lo        (cnt_lo[gi]),
            .hi_shadow (cnt_sh[gi])
         );
      end
   endgenerate

   // Interrupt arbitration: MEI > MSI > MTI
   always_comb begin
      irq_take = mstatus_mie_reg && |(mip_word & mie_word);
      if (meip_reg && meie_reg)      irq_code = IRQ_MEI;
      else if (msip_reg && msie_reg) irq_code = IRQ_MSI;
      else if (mtip_reg && mtie_reg) irq_code = IRQ_MTI;
      else                           irq_code = 4'd0;
   end

   // Vectored mode only applies to interrupts
   assign trap_vector = (exc_is_irq && mtvec_mode_reg)
                      ? {mtvec_base_reg, 2'b00} + {26'd0, exc_code, 2'b00}
                      : {mtvec_base_reg, 2'b00};

   assign mepc_out    = mepc_reg;
   assign csr_rvalid  = rvalid_reg;
   assign csr_rdata   = rdata_reg;
   assign csr_illegal = illegal_reg;

endmodule
